fifo_rr_sched: RTL and testbench
================================

FIFO_RR_SCHED -- requirements
Module: fifo_rr_sched

Interface
REQ-001 Parameter WIDTH, 16, data width of each served FIFO.
REQ-002 Parameter NQ, 4, number of FIFOs served; legal range 2..16.
REQ-003 Parameter BURST, 4, maximum consecutive pops granted to one FIFO per turn; legal range 1..255.
REQ-004 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 flush  input  1  global flush request.
REQ-008 q_empty  input  NQ  per-FIFO empty flag.
REQ-009 q_rdata  input  NQ*WIDTH  per-FIFO zero-latency read data; FIFO i occupies bits [i*WIDTH +: WIDTH].
REQ-010 q_pop  output  NQ  per-FIFO pop strobe, at most one bit set.
REQ-011 q_flush  output  NQ  per-FIFO flush, all bits equal to flush.
REQ-012 out_ready  input  1  downstream accepts a word.
REQ-013 out_valid  output  1  out_data/out_qid are valid.
REQ-014 out_data  output  WIDTH  word from the granted FIFO.
REQ-015 out_qid  output  $clog2(NQ)  index of the granted FIFO.

Function
REQ-016 The FSM SHALL have exactly two states, IDLE and SERVE, plus the registers cur (granted index), last (last served index) and bcnt (8-bit count of pops in the current turn).
REQ-017 In IDLE with any q_empty bit low, the next state SHALL be SERVE, with cur = the first non-empty index, searching round-robin from last+1 mod NQ, and bcnt = 0.
REQ-018 In IDLE with all FIFOs empty, the FSM SHALL stay in IDLE with out_valid = 0 and q_pop = 0.
REQ-019 out_valid SHALL equal (state == SERVE) && !q_empty[cur]; out_data SHALL equal q_rdata[cur]; out_qid SHALL equal cur; all three are combinational from the current state.
REQ-020 q_pop[cur] SHALL equal out_valid && out_ready && !flush, and every other q_pop bit SHALL be 0.
REQ-021 Each pop SHALL increment bcnt.
REQ-022 The turn SHALL end on a pop that brings bcnt to BURST, or in any SERVE cycle where q_empty[cur] = 1; on turn end, last SHALL be set to cur.
REQ-023 On turn end, if any FIFO other than cur is non-empty, the FSM SHALL stay in SERVE, with cur = the round-robin pick starting at cur+1 and bcnt = 0; otherwise the next state SHALL be IDLE.
REQ-024 A FIFO that becomes empty in the same cycle as its last pop SHALL end its turn in the following cycle; that cycle shows out_valid = 0, and no bubble beyond that one cycle is allowed.
REQ-025 When out_ready = 0, the state, cur and bcnt SHALL hold and the output data SHALL stay stable, provided q_empty[cur] is unchanged.
REQ-026 Throughput SHALL be one word per cycle within a turn; latency from a FIFO becoming non-empty while in IDLE to out_valid SHALL be 1 cycle.
REQ-027 flush = 1 SHALL force q_pop = 0 and next state IDLE, and SHALL reset bcnt to 0 and last to NQ-1, both on the next edge.
REQ-028 BURST = 1 SHALL yield strict per-word round-robin.
REQ-029 With a single non-empty FIFO, that FIFO SHALL be re-granted back-to-back, with bcnt restarting at 0 each turn.

Reset
REQ-030 While rst_n = 0, state SHALL be IDLE, cur = 0, last = NQ-1 and bcnt = 0.
REQ-031 While rst_n = 0, out_valid = 0, q_pop = 0, out_qid = 0 and out_data = q_rdata[0].
REQ-032 Reset asserted mid-turn SHALL abort the turn immediately, with no pop issued after the asserting edge.
REQ-033 The first grant after reset SHALL search from index 0.

Structure
REQ-034 Package fifo_sched_pkg SHALL hold the state enum (IDLE, SERVE) and the BCNT_W = 8 constant.
REQ-035 Round-robin selection SHALL be one combinational sub-module, rr_pick (inputs: request vector and start index; outputs: found flag and chosen index), instantiated once.
REQ-036 The block SHALL contain no storage for data words; buffering remains in the attached FIFOs.

Verification
REQ-037 Scenario: NQ=4, BURST=4; FIFO0 holds 6 words, FIFO2 holds 3 words, out_ready = 1 -> pops in order 0,0,0,0,2,2,2,0,0, then IDLE.
REQ-038 Scenario: BURST=1; all four FIFOs hold 2 words -> qid sequence 0,1,2,3,0,1,2,3, with no gaps.
REQ-039 Scenario: FIFO1 has 5 words, out_ready toggles 1,0,0,1 -> exactly 2 pops, and out_data is stable during the 0 cycles.
REQ-040 Scenario: flush asserted during the 2nd pop of a turn -> q_pop = 0 that cycle, q_flush = 4'b1111, and state = IDLE next cycle.
REQ-041 Scenario: rst_n dropped mid-turn with FIFO3 serving -> out_valid = 0 immediately; after release, with FIFO1 and FIFO3 non-empty, the first grant goes to 1.
REQ-042 Scenario: only FIFO2 has 9 words, BURST=4 -> 9 consecutive pops, with the qid constant at 2 and no bubbles.

Source files
------------

// File: rtl/fifo_rr_sched_pkg.sv
// fifo_sched_pkg: shared scheduler state encoding and burst-counter width
package fifo_sched_pkg;
  typedef enum logic {IDLE, SERVE} state_e;
  localparam int BCNT_W = 8;
endpackage

// File: rtl/fifo_rr_sched_if.sv
// fifo_rr_sched_if: FIFO-side and downstream-side signals of the round-robin scheduler
interface fifo_rr_sched_if #(
  parameter int WIDTH = 16,
  parameter int NQ    = 4
);
  logic                   flush;
  logic [NQ-1:0]          q_empty;
  logic [NQ*WIDTH-1:0]    q_rdata;
  logic [NQ-1:0]          q_pop;
  logic [NQ-1:0]          q_flush;
  logic                   out_ready;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic [$clog2(NQ)-1:0]  out_qid;
  modport master (
    output flush, q_empty, q_rdata, out_ready,
    input  q_pop, q_flush, out_valid, out_data, out_qid
  );
  modport slave (
    input  flush, q_empty, q_rdata, out_ready,
    output q_pop, q_flush, out_valid, out_data, out_qid
  );
endinterface

// File: rtl/fifo_rr_sched_rr_pick.sv
// rr_pick: first set request bit at or after start_i, wrapping modulo NQ
module rr_pick #(
  parameter int NQ = 4
) (
  input  logic [NQ-1:0]         req_i,
  input  logic [$clog2(NQ)-1:0] start_i,
  output logic                  found_o,
  output logic [$clog2(NQ)-1:0] idx_o
);
  localparam int IW = $clog2(NQ);
  logic [IW-1:0] cand;
  // Scan farthest offset first so the nearest hit overwrites earlier ones
  always_comb begin
    found_o = 1'b0;
    idx_o   = start_i;
    cand    = '0;
    for (int j = NQ - 1; j >= 0; j--) begin
      cand = IW'((int'(start_i) + j) % NQ);
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end
endmodule

// File: rtl/fifo_rr_sched.sv
// fifo_rr_sched: round-robin pop scheduler over NQ FIFOs with a per-turn burst limit
module fifo_rr_sched
  import fifo_sched_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NQ    = 4,
  parameter int BURST = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  fifo_rr_sched_if.slave bus
);
  localparam int IW = $clog2(NQ);
  state_e            state_q;
  logic [IW-1:0]     cur_q, last_q;
  logic [BCNT_W-1:0] bcnt_q;
  logic              pop, turn_end, found;
  logic [IW-1:0]     base, start, pick;
  assign bus.out_valid = (state_q == SERVE) && !bus.q_empty[cur_q];
  assign bus.out_data  = bus.q_rdata[cur_q*WIDTH +: WIDTH];
  assign bus.out_qid   = cur_q;
  assign bus.q_flush   = {NQ{bus.flush}};
  assign pop           = bus.out_valid && bus.out_ready && !bus.flush;
  assign bus.q_pop     = pop ? NQ'(1) << cur_q : '0;
  assign turn_end      = bus.q_empty[cur_q] || (pop && bcnt_q == BCNT_W'(BURST - 1));
  // Searching from cur+1 over all FIFOs prefers others and re-grants cur last
  assign base          = (state_q == SERVE) ? cur_q : last_q;
  assign start         = (base == IW'(NQ - 1)) ? '0 : base + 1'b1;
  rr_pick #(.NQ(NQ)) u_pick (
    .req_i   (~bus.q_empty),
    .start_i (start),
    .found_o (found),
    .idx_o   (pick)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      last_q  <= IW'(NQ - 1);
      bcnt_q  <= '0;
    end else if (bus.flush) begin
      state_q <= IDLE;
      last_q  <= IW'(NQ - 1);
      bcnt_q  <= '0;
    end else if (state_q == IDLE || turn_end) begin
      if (state_q == SERVE) last_q <= cur_q;
      state_q <= found ? SERVE : IDLE;
      if (found) cur_q <= pick;
      bcnt_q  <= '0;
    end else if (pop) begin
      bcnt_q  <= bcnt_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_rr_sched.sv
// tb_fifo_rr_sched: two schedulers (BURST 4 and 1) against a queue-level model plus directed scenarios
module tb_fifo_rr_sched;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, out_ready = 1'b0;
  always #5 clk = ~clk;
  int cnt[2][4];
  int hd[2][4];
  logic [1:0]            ov;
  logic [1:0][3:0]       pop, qf;
  logic [1:0][15:0]      od;
  logic [1:0][1:0]       qid;
  int checks = 0, errors = 0, cyc = 0;
  logic [63:0] seqv[2];
  int npop[2], fc[2], lc[2];
  bit m_serve[2];
  int m_cur[2]  = '{0, 0};
  int m_last[2] = '{3, 3};
  int m_bcnt[2] = '{0, 0};

  function automatic logic [15:0] word(int k, int i, int n);
    return {4'(k), 4'(i), 8'(n)};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fifo_rr_sched_if #(.WIDTH(16), .NQ(4)) ifc ();
    fifo_rr_sched #(.WIDTH(16), .NQ(4), .BURST(g == 0 ? 4 : 1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
    );
    assign ifc.flush     = flush;
    assign ifc.out_ready = out_ready;
    for (genvar i = 0; i < 4; i++) begin : g_q
      assign ifc.q_empty[i]         = cnt[g][i] == 0;
      assign ifc.q_rdata[i*16 +: 16] = word(g, i, hd[g][i]);
    end
    assign ov[g]  = ifc.out_valid;
    assign pop[g] = ifc.q_pop;
    assign qf[g]  = ifc.q_flush;
    assign od[g]  = ifc.out_data;
    assign qid[g] = ifc.out_qid;
  end

  task automatic chk(string nm, int k, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h at cycle %0d", nm, k, act, exp, cyc);
    end
  endtask

  function automatic int pick(int k, int from);
    for (int j = 1; j <= 4; j++) begin
      int t;
      t = (from + j) % 4;
      if (cnt[k][t] > 0) return t;
    end
    return -1;
  endfunction

  // Scheduler model: who is granted, which index served last, pops used this turn
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      int burst, p;
      bit popd;
      burst = (k == 0) ? 4 : 1;
      if (!rst_n) begin
        m_serve[k] = 0; m_cur[k] = 0; m_last[k] = 3; m_bcnt[k] = 0;
      end else begin
        popd = m_serve[k] && cnt[k][m_cur[k]] > 0 && out_ready && !flush;
        if (flush) begin
          m_serve[k] = 0; m_bcnt[k] = 0; m_last[k] = 3;
        end else if (!m_serve[k]) begin
          p = pick(k, m_last[k]);
          if (p >= 0) begin m_serve[k] = 1; m_cur[k] = p; m_bcnt[k] = 0; end
        end else if (cnt[k][m_cur[k]] == 0 || m_bcnt[k] + int'(popd) == burst) begin
          m_last[k] = m_cur[k];
          p = pick(k, m_cur[k]);
          m_bcnt[k] = 0;
          if (p >= 0) m_cur[k] = p;
          else m_serve[k] = 0;
        end else begin
          m_bcnt[k] += int'(popd);
        end
      end
    end
  end

  // Attached FIFOs: consume popped words just after the edge that popped them
  always @(posedge clk) begin
    logic [1:0][3:0] ps;
    int c;
    ps = pop;
    c  = cyc;
    #1;
    cyc = cyc + 1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++)
        if (ps[k][i]) begin
          cnt[k][i] = cnt[k][i] - 1;
          hd[k][i]  = hd[k][i] + 1;
          seqv[k]   = {seqv[k][59:0], 4'(i)};
          if (npop[k] == 0) fc[k] = c;
          lc[k]   = c;
          npop[k] = npop[k] + 1;
        end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit ev;
      ev = m_serve[k] && cnt[k][m_cur[k]] > 0;
      chk("out_valid", k, ov[k], ev);
      chk("out_qid", k, qid[k], m_cur[k]);
      chk("out_data", k, od[k], word(k, m_cur[k], hd[k][m_cur[k]]));
      chk("q_pop", k, pop[k], (ev && out_ready && !flush) ? (64'd1 << m_cur[k]) : 64'd0);
      chk("q_flush", k, qf[k], flush ? 64'hf : 64'h0);
    end
  end

  task automatic step(int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic clr_log;
    for (int k = 0; k < 2; k++) begin seqv[k] = '0; npop[k] = 0; fc[k] = 0; lc[k] = 0; end
  endtask

  task automatic load(int i, int n);
    for (int k = 0; k < 2; k++) cnt[k][i] = n;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) begin cnt[k][i] = 0; hd[k][i] = 0; end
    @(negedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", k, ov[k], 0);
      chk("rst_pop", k, pop[k], 0);
      chk("rst_qid", k, qid[k], 0);
    end
    step(1);
    rst_n = 1'b1;
    clr_log();
  endtask

  task automatic drain(string nm);
    int t = 0;
    while ((cnt[0][0] + cnt[0][1] + cnt[0][2] + cnt[0][3] +
            cnt[1][0] + cnt[1][1] + cnt[1][2] + cnt[1][3]) > 0 && t < 80) begin
      step(1);
      t++;
    end
    checks++;
    if (t >= 80) begin errors++; $display("FAIL %s drain timeout: got %0d cycles, limit 80", nm, t); end
    step(3);
  endtask

  initial begin
    // Two FIFOs, burst-limited turns
    do_reset();
    out_ready = 1'b1;
    load(0, 6); load(2, 3);
    drain("s37");
    chk("s37_seq", 0, seqv[0], 64'h000022200);
    chk("s37_seq", 1, seqv[1], 64'h020202000);
    chk("s37_n", 0, npop[0], 9);
    chk("s37_n", 1, npop[1], 9);
    // All four FIFOs with two words each
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) load(i, 2);
    drain("s38");
    chk("s38_seq", 0, seqv[0], 64'h00112233);
    chk("s38_seq", 1, seqv[1], 64'h01230123);
    chk("s38_span", 0, lc[0] - fc[0] + 1, 11);
    chk("s38_span", 1, lc[1] - fc[1] + 1, 8);
    // Backpressure holds grant and data
    do_reset();
    load(1, 5);
    step(1);
    out_ready = 1'b1; step(1);
    out_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        chk("s39_valid", k, ov[k], 1);
        chk("s39_hold", k, od[k], word(k, 1, 1));
      end
      step(1);
    end
    out_ready = 1'b1; step(1);
    out_ready = 1'b0; step(2);
    for (int k = 0; k < 2; k++) begin
      chk("s39_n", k, npop[k], 2);
      chk("s39_seq", k, seqv[k], 64'h11);
    end
    out_ready = 1'b1;
    drain("s39");
    // Flush during the second pop
    do_reset();
    out_ready = 1'b1;
    load(0, 6);
    step(2);
    flush = 1'b1;
    @(negedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      chk("s40_pop", k, pop[k], 0);
      chk("s40_qflush", k, qf[k], 4'hf);
    end
    step(1);
    flush = 1'b0;
    @(negedge clk); #1;
    for (int k = 0; k < 2; k++) chk("s40_idle", k, ov[k], 0);
    drain("s40");
    for (int k = 0; k < 2; k++) chk("s40_n", k, npop[k], 6);
    // Reset mid-turn, then grant from index 0 upward
    do_reset();
    out_ready = 1'b1;
    load(3, 5);
    step(3);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("s41_valid", k, ov[k], 0);
      chk("s41_pop", k, pop[k], 0);
      chk("s41_left", k, cnt[k][3], 3);
    end
    load(1, 3);
    step(1);
    rst_n = 1'b1;
    clr_log();
    drain("s41");
    chk("s41_seq", 0, seqv[0], 64'h111333);
    chk("s41_seq", 1, seqv[1], 64'h131313);
    // Single FIFO re-granted without bubbles
    do_reset();
    out_ready = 1'b1;
    load(2, 9);
    drain("s42");
    for (int k = 0; k < 2; k++) begin
      chk("s42_seq", k, seqv[k], 64'h222222222);
      chk("s42_span", k, lc[k] - fc[k] + 1, 9);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
